seg7_scan_display: RTL and testbench

//  Downstream display stage for single-cycle CPU outputs: shows syscall hex word or one

---
 rtl/seg7_scan_display.sv | 125 ++++++++++++
 tb/tb_seg7_scan_display.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
//==============================================================================
// Module   : seg7_scan_display
// Purpose  : 8-digit multiplexed 7-segment scanner with a frame-latched snapshot.
//            Optional macro SEG7_BLANK_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg7_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  sel,
  input  logic [31:0] hex,
  input  logic [10:0] cnt_i,
  input  logic [10:0] cnt_r,
  input  logic [10:0] cnt_j,
  input  logic [10:0] cnt_clk,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] c_tick_max = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] prescaler_q, prescaler_d;
  logic [2:0]       digit_q, digit_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             frame_edge;
  logic [31:0]      src_word;
  logic [3:0]       nibble;
  logic             blank;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0:    enc = 7'h40;
      4'h1:    enc = 7'h79;
      4'h2:    enc = 7'h24;
      4'h3:    enc = 7'h30;
      4'h4:    enc = 7'h19;
      4'h5:    enc = 7'h12;
      4'h6:    enc = 7'h02;
      4'h7:    enc = 7'h78;
      4'h8:    enc = 7'h00;
      4'h9:    enc = 7'h10;
      4'hA:    enc = 7'h08;
      4'hB:    enc = 7'h03;
      4'hC:    enc = 7'h46;
      4'hD:    enc = 7'h21;
      4'hE:    enc = 7'h06;
      default: enc = 7'h0E;
    endcase
  endfunction

  always_comb begin
    src_word = 32'h0;
    case (sel)
      3'd0:    src_word = hex;
      3'd1:    src_word = {21'h0, cnt_i};
      3'd2:    src_word = {21'h0, cnt_r};
      3'd3:    src_word = {21'h0, cnt_j};
      3'd4:    src_word = {21'h0, cnt_clk};
      default: src_word = 32'h0;
    endcase
  end

  // Scan timing and snapshot: sources are sampled only on the last tick of a frame.
  always_comb begin
    tick        = (prescaler_q == c_tick_max);
    frame_edge  = tick && (digit_q == 3'd7);
    prescaler_d = tick ? '0 : prescaler_q + DIV_W'(1);
    digit_d     = tick ? digit_q + 3'd1 : digit_q;
    snap_d      = frame_edge ? src_word : snap_q;
  end

  always_comb begin
    nibble = snap_q[{digit_q, 2'b00} +: 4];
`ifdef SEG7_BLANK_EN
    blank  = (digit_q != 3'd0) && ((snap_q >> {digit_q, 2'b00}) == 32'h0);
`else
    blank  = 1'b0;
`endif
    an_d         = blank ? 8'hFF : ~(8'b1 << digit_q);
    seg_d        = blank ? 7'h7F : enc(nibble);
    dp_d         = 1'b1;
    frame_done_d = frame_edge;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q  <= '0;
      digit_q      <= 3'd0;
      snap_q       <= 32'h0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_q      <= digit_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
//==============================================================================
// Module   : tb_seg7_scan_display
// Purpose  : Directed vector bench for seg7_scan_display (SCAN_DIV=2 and =1).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seg7_scan_display;

  logic        clk;
  logic        reset;
  logic [2:0]  sel;
  logic [31:0] hex;
  logic [10:0] cnt_i, cnt_r, cnt_j, cnt_clk;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;

  int n_vec = 0;
  int n_bad = 0;

  seg7_scan_display #(.SCAN_DIV(2), .DIV_W(4)) dut0 (
    .clk(clk), .reset(reset), .sel(sel), .hex(hex),
    .cnt_i(cnt_i), .cnt_r(cnt_r), .cnt_j(cnt_j), .cnt_clk(cnt_clk),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
  );

  seg7_scan_display #(.SCAN_DIV(1), .DIV_W(2)) dut1 (
    .clk(clk), .reset(reset), .sel(sel), .hex(hex),
    .cnt_i(cnt_i), .cnt_r(cnt_r), .cnt_j(cnt_j), .cnt_clk(cnt_clk),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       sel;
    logic [31:0]      hex;
    logic [10:0]      ci, cr, cj, cc;
    logic [31:0]      word;
    logic [7:0][6:0]  segs;   // hand-written codes, digit 7 first in the literal
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(input logic [2:0] s, input logic [31:0] h,
                              input logic [10:0] ci, input logic [10:0] cr,
                              input logic [10:0] cj, input logic [10:0] cc,
                              input logic [31:0] w, input logic [55:0] sg);
    vec_t v;
    v.sel = s; v.hex = h; v.ci = ci; v.cr = cr; v.cj = cj; v.cc = cc;
    v.word = w; v.segs = sg;
    return v;
  endfunction

  function automatic logic is_blank(input logic [31:0] w, input int d);
`ifdef SEG7_BLANK_EN
    return (d != 0) && ((w >> (4 * d)) == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    sel = v.sel; hex = v.hex; cnt_i = v.ci; cnt_r = v.cr; cnt_j = v.cj; cnt_clk = v.cc;
  endtask

  task automatic chk(input string nm, input logic [7:0] a, input logic [6:0] s,
                     input logic p, input logic f, input logic [31:0] w,
                     input int d, input logic [6:0] hs, input logic ef);
    logic [7:0] ea;
    logic [6:0] es;
    ea = is_blank(w, d) ? 8'hFF : ~(8'b1 << d);
    es = is_blank(w, d) ? 7'h7F : hs;
    n_vec++;
    if ({a, s, p, f} !== {ea, es, 1'b1, ef}) begin
      n_bad++;
      $display("FAIL %s digit%0d: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=1 fd=%b",
               nm, d, a, s, p, f, ea, es, ef);
    end
  endtask

  task automatic chk_rst(input string nm, input logic [7:0] a, input logic [6:0] s,
                         input logic p, input logic f);
    n_vec++;
    if ({a, s, p, f} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=ff seg=7f dp=1 fd=0",
               nm, a, s, p, f);
    end
  endtask

  task automatic wait_fd0();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!fd0 && n < 40);
    if (!fd0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_frame_done: got no pulse in %0d clk, want one within 16", n);
    end
  endtask

  // First frame after reset: dut0 shows zero; dut1 (one clk per digit) loads hex after 8 clk.
  task automatic first_frame(input string nm);
    for (int j = 0; j < 16; j++) begin
      int d1;
      step();
      d1 = j % 8;
      chk({nm, "_div2"}, an0, seg0, dp0, fd0, 32'h0, j >> 1, 7'h40, j == 15);
      chk({nm, "_div1"}, an1, seg1, dp1, fd1, (j < 8) ? 32'h0 : vt[0].word, d1,
          (j < 8) ? 7'h40 : vt[0].segs[d1], (j == 7) || (j == 15));
    end
  endtask

  initial begin
    vt[0] = mk(3'd0, 32'h1234ABCD, 11'h2C1, 11'h3D2, 11'h4E3, 11'h5F4, 32'h1234ABCD,
               {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
    vt[1] = mk(3'd2, 32'hDEADBEEF, 11'h2C1, 11'h7FF, 11'h4E3, 11'h5F4, 32'h000007FF,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h0E, 7'h0E});
    vt[2] = mk(3'd1, 32'hDEADBEEF, 11'h5A3, 11'h3D2, 11'h4E3, 11'h5F4, 32'h000005A3,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h08, 7'h30});
    vt[3] = mk(3'd3, 32'hDEADBEEF, 11'h2C1, 11'h3D2, 11'h06E, 11'h5F4, 32'h0000006E,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h02, 7'h06});
    vt[4] = mk(3'd4, 32'hDEADBEEF, 11'h2C1, 11'h3D2, 11'h4E3, 11'h1F9, 32'h000001F9,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h0E, 7'h10});
    vt[5] = mk(3'd5, 32'hDEADBEEF, 11'h2C1, 11'h3D2, 11'h4E3, 11'h5F4, 32'h0,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    vt[6] = mk(3'd0, 32'h76543210, 11'h2C1, 11'h3D2, 11'h4E3, 11'h5F4, 32'h76543210,
               {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});
    vt[7] = mk(3'd0, 32'hFEDCBA98, 11'h2C1, 11'h3D2, 11'h4E3, 11'h5F4, 32'hFEDCBA98,
               {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00});
    vt[8] = mk(3'd7, 32'hDEADBEEF, 11'h2C1, 11'h3D2, 11'h4E3, 11'h5F4, 32'h0,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    vt[9] = mk(3'd0, 32'h00000050, 11'h2C1, 11'h3D2, 11'h4E3, 11'h5F4, 32'h00000050,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h40});

    // Power-on reset, then the first frame and the SCAN_DIV=1 rotation.
    reset = 1'b1;
    apply(vt[0]);
    repeat (3) @(negedge clk);
    chk_rst("por_div2", an0, seg0, dp0, fd0);
    chk_rst("por_div1", an1, seg1, dp1, fd1);
    reset = 1'b0;
    first_frame("por");

    // Table: each vector is latched at the next boundary and shown for a full frame.
    for (int v = 0; v < 10; v++) begin
      apply(vt[v]);
      wait_fd0();
      for (int j = 0; j < 16; j++) begin
        step();
        chk($sformatf("vec%0d", v), an0, seg0, dp0, fd0, vt[v].word, j >> 1,
            vt[v].segs[j >> 1], j == 15);
      end
    end

    // sel changes while digit 3 is being scanned; the frame must not tear.
    apply(vt[0]);
    cnt_j = 11'h06E;
    wait_fd0();
    for (int j = 0; j < 16; j++) begin
      step();
      if (j == 6) sel = 3'd3;
      chk("midframe_old", an0, seg0, dp0, fd0, vt[0].word, j >> 1, vt[0].segs[j >> 1], j == 15);
    end
    for (int j = 0; j < 16; j++) begin
      step();
      chk("midframe_new", an0, seg0, dp0, fd0, vt[3].word, j >> 1, vt[3].segs[j >> 1], j == 15);
    end

    // Asynchronous reset mid-scan, between clock edges.
    apply(vt[0]);
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    chk_rst("async_rst_div2", an0, seg0, dp0, fd0);
    chk_rst("async_rst_div1", an1, seg1, dp1, fd1);
    step();
    chk_rst("held_rst_div2", an0, seg0, dp0, fd0);
    reset = 1'b0;
    first_frame("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
